note_sequencer: RTL
===================

# note_sequencer

Parametrised beat-quantised note recorder/player for the guitar front end. It contains a tempo divider that produces one beat per period. In record mode it ORs string/fret presses over each beat window, encodes them into a one-hot note word and writes one word per beat into internal memory. In play mode it replays the stored words at the selected tempo to the audio path, once or looped.

## Interface
- NUM_STRINGS, 5, number of string inputs.
- NUM_FRETS, 5, number of fret inputs.
- DEPTH, 64, note memory depth in beats; ADDR_W = clog2(DEPTH).
- GUARD, 10000, closed-window cycles at the end of each beat.
- SIM_PERIOD, 0, if nonzero overrides the tempo table period (cycles).
- NOTE_W (derived) = NUM_STRINGS*(NUM_FRETS+1).
- clk  in  1  system clock, 50 MHz.
- resetn  in  1  reset, synchronous, active-low.
- tempo_sel  in  3  tempo index into the period table.
- mode  in  1  0 = record, 1 = play; sampled on start.
- start  in  1  one-cycle pulse; honoured only in IDLE.
- stop  in  1  one-cycle pulse; ends RECORD or PLAY.
- loop  in  1  play wraps to address 0 at end; sampled continuously.
- strings  in  NUM_STRINGS  string presses, active-high, already synchronised.
- frets  in  NUM_FRETS  fret presses, active-high.
- note_out  out  NOTE_W  played note word.
- note_valid  out  1  one-cycle strobe that note_out is new.
- beat_tick  out  1  one-cycle beat strobe.
- window_open  out  1  accumulation window indicator (recording LED).
- busy  out  1  high in RECORD or PLAY.
- full  out  1  last recording stopped on DEPTH.
- rec_len  out  ADDR_W+1  beats stored by the last recording.

## Operation
- Reset values: all outputs 0, state IDLE, rec_len 0, accumulators 0. Memory contents are undefined and are not playable, because rec_len is 0.
- The FSM has three states: IDLE, RECORD and PLAY.
- IDLE -> RECORD: start with mode=0. This clears addr, the accumulators, rec_len and full.
- IDLE -> PLAY: start with mode=1 and rec_len != 0. Sets addr=0. If rec_len == 0, start is ignored.
- Entering either active state reloads the divider to period-1, so the first beat_tick falls exactly one period after start.
- RECORD behaviour:
  - On every cycle with window_open=1: acc_s |= strings, acc_f |= frets.
  - On beat_tick: mem[addr] <= encode(acc_s, acc_f), addr++, rec_len++, accumulators cleared.
  - encode: bit s+NUM_STRINGS*f = acc_s[s] & acc_f[f] for f < NUM_FRETS. Bit s+NUM_STRINGS*NUM_FRETS = acc_s[s] & ~|acc_f (open string). Fret presses with no string press encode to 0 and are still written.
  - After the write that makes rec_len == DEPTH: full=1, go to IDLE.
  - stop -> IDLE; the partial beat is discarded. If stop and beat_tick coincide, the write happens first, then IDLE.
- PLAY behaviour:
  - On beat_tick: read mem[addr], addr++.
  - After reading the rec_len-1 entry: with loop=1, addr=0; otherwise go to IDLE once the read completes.
  - stop -> IDLE immediately; a pending read is dropped.
- note_out holds its last value while in PLAY and clears to 0 on the cycle after leaving PLAY.
- start while busy is ignored. mode changes while busy are ignored.

## Timing
- Divider: counter runs from period-1 down to 0.
  - beat_tick = (counter == 0).
  - window_open = busy & (counter >= GUARD).
- Period table at 50 MHz, indexed by tempo_sel 0..7: 75 000 000, 50 000 000, 37 500 000, 30 000 000, 25 000 000, 21 428 571, 16 666 667, 13 636 364 cycles.
- tempo_sel is sampled only at reload, so a tempo change takes effect on the next beat.
- If GUARD >= period, window_open stays 0.
- In IDLE the divider free-runs, so beat_tick can drive a metronome LED.
- Record write lands in the beat_tick cycle. A press in that cycle (window closed) is not captured.
- Play latency: note_out and note_valid are registered exactly 1 cycle after beat_tick, using a synchronous-read memory (block RAM inferable).
- The counter is 27 bits wide; addr wraps modulo DEPTH. rec_len saturates at DEPTH.

## Structure
- Package note_seq_pkg holds the state enum, the tempo period table, default GUARD, and the encode function.
- Sub-module tempo_divider (clk, resetn, tempo_sel, reload, beat_tick, window_open, with GUARD and SIM_PERIOD parameters) holds the counter and period mux.
- The memory is an inferred array inside note_sequencer.

## Test plan
All scenarios use SIM_PERIOD=20, GUARD=4, DEPTH=4.
- Reset: resetn low for 2 cycles -> all outputs 0, rec_len=0. A following start with mode=1 -> busy stays 0.
- Record 2 beats:
  - Beat 1: strings=5'b00010 and frets=5'b00001 pulsed inside the window -> word bit 1.
  - Beat 2: strings=5'b00001 with no fret -> bit 25.
  - stop -> rec_len=2, full=0.
- Play once: start mode=1, loop=0 -> note_valid one cycle after each of 2 beat_ticks with note_out=1<<1 then 1<<25, then IDLE and note_out=0.
- Full: record 4 beats -> full=1, rec_len=4, IDLE on the 4th tick. A press in the tick cycle is not in the word.
- Loop and stop: play with rec_len=2, loop=1 -> sequence 1<<1, 1<<25, 1<<1. stop mid-period -> busy=0 next cycle.
- Stop coinciding with beat_tick during record -> that beat is written and rec_len increments. Reset mid-record -> rec_len=0, busy=0.

Source files
------------

// File: rtl/note_seq_pkg.sv
// Shared types, tempo table and note-word encoder for the note sequencer.
package note_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECORD,
        ST_PLAY
    } seq_state_t;

    localparam int CNT_W         = 27;
    localparam int DEFAULT_GUARD = 10000;

    // Beat periods in 50 MHz cycles, indexed by tempo_sel
    localparam logic [CNT_W-1:0] PERIOD_TABLE [8] = '{
        27'd75000000, 27'd50000000, 27'd37500000, 27'd30000000,
        27'd25000000, 27'd21428571, 27'd16666667, 27'd13636364
    };

    // Upper bounds so the encoder can live here without module parameters
    localparam int STR_MAX    = 16;
    localparam int FRET_MAX   = 16;
    localparam int NOTE_MAX_W = STR_MAX * (FRET_MAX + 1);

    // One-hot-per-string note word: bit s+ns*f for string s on fret f,
    // bit s+ns*nf for string s played open (no fret held).
    function automatic logic [NOTE_MAX_W-1:0] encode(
        input logic [STR_MAX-1:0]  acc_s,
        input logic [FRET_MAX-1:0] acc_f,
        input int                  ns,
        input int                  nf
    );
        logic [NOTE_MAX_W-1:0] word;
        logic [STR_MAX-1:0]    s_sh;
        logic [FRET_MAX-1:0]   f_sh;
        word = '0;
        for (int si = 0; si < STR_MAX; si++) begin
            s_sh = acc_s >> si;
            if (si < ns) begin
                for (int fi = 0; fi < FRET_MAX; fi++) begin
                    f_sh = acc_f >> fi;
                    if (fi < nf)
                        word |= NOTE_MAX_W'(s_sh[0] & f_sh[0]) << (si + ns * fi);
                end
                word |= NOTE_MAX_W'(s_sh[0] & ~|acc_f) << (si + ns * nf);
            end
        end
        return word;
    endfunction

endpackage

// File: rtl/note_seq_if.sv
// Control, press inputs and playback/status outputs of the note sequencer.
interface note_seq_if #(
    parameter int NUM_STRINGS = 5,
    parameter int NUM_FRETS   = 5,
    parameter int ADDR_W      = 6
) ();
    localparam int NOTE_W = NUM_STRINGS * (NUM_FRETS + 1);

    logic [2:0]             tempo_sel;
    logic                   mode;
    logic                   start;
    logic                   stop;
    logic                   loop;
    logic [NUM_STRINGS-1:0] strings;
    logic [NUM_FRETS-1:0]   frets;
    logic [NOTE_W-1:0]      note_out;
    logic                   note_valid;
    logic                   beat_tick;
    logic                   window_open;
    logic                   busy;
    logic                   full;
    logic [ADDR_W:0]        rec_len;

    modport master (
        output tempo_sel, mode, start, stop, loop, strings, frets,
        input  note_out, note_valid, beat_tick, window_open, busy, full, rec_len
    );

    modport slave (
        input  tempo_sel, mode, start, stop, loop, strings, frets,
        output note_out, note_valid, beat_tick, window_open, busy, full, rec_len
    );
endinterface

// File: rtl/tempo_divider.sv
// Beat divider: counts period-1 down to 0, ticks at 0, window open above GUARD.
module tempo_divider
    import note_seq_pkg::*;
#(
    parameter int GUARD      = DEFAULT_GUARD,
    parameter int SIM_PERIOD = 0
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [2:0] tempo_sel,
    input  logic       reload,
    output logic       beat_tick,
    output logic       window_open
);
    localparam logic [31:0] GUARD_U = GUARD;

    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] period;

    // Period source: simulation override or the tempo table
    always_comb begin
        period = (SIM_PERIOD != 0) ? CNT_W'(SIM_PERIOD) : PERIOD_TABLE[tempo_sel];
    end

    // Free-running down counter; tempo is picked up only when it reloads
    always_ff @(posedge clk) begin
        if (!resetn || reload || counter == '0)
            counter <= period - 1'b1;
        else
            counter <= counter - 1'b1;
    end

    assign beat_tick   = (counter == '0);
    assign window_open = ({{(32 - CNT_W){1'b0}}, counter} >= GUARD_U);

endmodule

// File: rtl/note_sequencer.sv
// Beat-quantised note recorder/player: records one encoded word per beat, replays at tempo.
module note_sequencer
    import note_seq_pkg::*;
#(
    parameter int NUM_STRINGS = 5,
    parameter int NUM_FRETS   = 5,
    parameter int DEPTH       = 64,
    parameter int GUARD       = DEFAULT_GUARD,
    parameter int SIM_PERIOD  = 0
) (
    input  logic      clk,
    input  logic      resetn,
    note_seq_if.slave bus
);
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NOTE_W = NUM_STRINGS * (NUM_FRETS + 1);

    seq_state_t             state, state_nxt;
    logic                   reload, beat_tick, win_raw, window_open;
    logic                   rec_start, play_start, wr_en, rd_en;
    logic                   last_rd, last_wr;
    logic [ADDR_W-1:0]      addr, addr_inc;
    logic [ADDR_W:0]        rec_len;
    logic                   full;
    logic [NUM_STRINGS-1:0] acc_s;
    logic [NUM_FRETS-1:0]   acc_f;
    logic [NOTE_W-1:0]      wr_word;
    logic [NOTE_W-1:0]      mem [DEPTH];
    logic [NOTE_W-1:0]      note_p1;
    logic                   vld_p1;

    tempo_divider #(
        .GUARD      (GUARD),
        .SIM_PERIOD (SIM_PERIOD)
    ) u_div (
        .clk         (clk),
        .resetn      (resetn),
        .tempo_sel   (bus.tempo_sel),
        .reload      (reload),
        .beat_tick   (beat_tick),
        .window_open (win_raw)
    );

    assign window_open = (state != ST_IDLE) & win_raw;
    assign addr_inc    = (addr == ADDR_W'(DEPTH - 1)) ? '0 : addr + 1'b1;
    assign last_rd     = ({1'b0, addr} == rec_len - 1'b1);
    assign last_wr     = (rec_len == (ADDR_W + 1)'(DEPTH - 1));
    assign wr_word     = NOTE_W'(encode(STR_MAX'(acc_s), FRET_MAX'(acc_f), NUM_STRINGS, NUM_FRETS));

    // State register
    always_ff @(posedge clk) begin
        if (!resetn)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next state and per-cycle strobes; a write on the stop cycle still lands
    always_comb begin
        state_nxt  = state;
        reload     = 1'b0;
        rec_start  = 1'b0;
        play_start = 1'b0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start && !bus.mode) begin
                    rec_start = 1'b1;
                    reload    = 1'b1;
                    state_nxt = ST_RECORD;
                end else if (bus.start && bus.mode && rec_len != '0) begin
                    play_start = 1'b1;
                    reload     = 1'b1;
                    state_nxt  = ST_PLAY;
                end
            end
            ST_RECORD: begin
                if (beat_tick) begin
                    wr_en = 1'b1;
                    if (last_wr || bus.stop)
                        state_nxt = ST_IDLE;
                end else if (bus.stop) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if (bus.stop) begin
                    state_nxt = ST_IDLE;
                end else if (beat_tick) begin
                    rd_en = 1'b1;
                    if (last_rd && !bus.loop)
                        state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Note memory write port, one word per recorded beat
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[addr] <= wr_word;
    end

    // Address, length, accumulators and the registered playback output
    always_ff @(posedge clk) begin
        if (!resetn) begin
            addr    <= '0;
            rec_len <= '0;
            full    <= 1'b0;
            acc_s   <= '0;
            acc_f   <= '0;
            note_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= rd_en;
            if (rd_en)
                note_p1 <= mem[addr];
            else if (state != ST_PLAY)
                note_p1 <= '0;

            if (rec_start) begin
                addr    <= '0;
                rec_len <= '0;
                full    <= 1'b0;
                acc_s   <= '0;
                acc_f   <= '0;
            end else if (play_start) begin
                addr <= '0;
            end else if (wr_en) begin
                addr    <= addr_inc;
                rec_len <= (rec_len == (ADDR_W + 1)'(DEPTH)) ? rec_len : rec_len + 1'b1;
                acc_s   <= '0;
                acc_f   <= '0;
                if (last_wr)
                    full <= 1'b1;
            end else if (rd_en) begin
                addr <= last_rd ? '0 : addr_inc;
            end else if (state == ST_RECORD && window_open) begin
                acc_s <= acc_s | bus.strings;
                acc_f <= acc_f | bus.frets;
            end
        end
    end

    assign bus.note_out    = note_p1;
    assign bus.note_valid  = vld_p1;
    assign bus.beat_tick   = beat_tick;
    assign bus.window_open = window_open;
    assign bus.busy        = (state != ST_IDLE);
    assign bus.full        = full;
    assign bus.rec_len     = rec_len;

endmodule
